seq_alu: RTL and testbench

Parametrised, multi-cycle successor to the single-cycle datapath ALU. It adds shifts and RISC-V M-extension multiply, divide and remainder to the base integer ops. Results are registered behind a start/valid handshake, so the multi-cycle execute stage can stall on it. Flags are computed from the registered result.

---
 rtl/seq_alu_if.sv | 25 ++
 rtl/seq_alu.sv | 209 ++++++++++++++++++++
 tb/tb_seq_alu.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// Start/valid request bus for seq_alu: operands and op in, registered result and flags out.
interface seq_alu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ready;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             neg;

  modport master (
    output start, op, A, B,
    input  ready, busy, valid, result, zero, neg
  );

  modport slave (
    input  start, op, A, B,
    output ready, busy, valid, result, zero, neg
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle integer/shift ops plus iterative shift-add multiply
// and restoring divide, all behind a start/valid handshake with registered result and flags.
module seq_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  seq_alu_if.slave   bus
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned W2  = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_SLT   = 4'd4;
  localparam logic [3:0] OP_SLTU  = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_SLL   = 4'd7;
  localparam logic [3:0] OP_SRL   = 4'd8;
  localparam logic [3:0] OP_SRA   = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;
  localparam logic [3:0] OP_DIV   = 4'd12;
  localparam logic [3:0] OP_DIVU  = 4'd13;
  localparam logic [3:0] OP_REM   = 4'd14;
  localparam logic [3:0] OP_REMU  = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [SHW-1:0]   cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] mcand;
  logic [W2-1:0]    acc;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quot;
  logic             q_neg, r_neg;
  logic             special;
  logic [WIDTH-1:0] special_res;

  logic             ready_q, busy_q, valid_q, zero_q, neg_q;
  logic [WIDTH-1:0] result_q;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             is_iter, is_mul, is_div, is_sdiv, is_rem;
  logic             a_sgn, b_sgn, b_zero, div_ovf;
  logic [WIDTH-1:0] a_mag, b_mag, spec_res;
  logic [WIDTH:0]   hi_sum, rem_sh;
  logic [W2-1:0]    acc_step;
  logic             rem_fit;
  logic [WIDTH-1:0] rem_step, quot_step, iter_res;
  logic             ld_res, ld_iter;
  logic [WIDTH-1:0] res_nxt;

  assign shamt = bus.B[SHW-1:0];

  // Single-cycle datapath, evaluated on the live request operands
  always_comb begin : alu_comb
    alu_res = '0;
    case (bus.op)
      OP_ADD:  alu_res = bus.A + bus.B;
      OP_SUB:  alu_res = bus.A - bus.B;
      OP_AND:  alu_res = bus.A & bus.B;
      OP_OR:   alu_res = bus.A | bus.B;
      OP_SLT:  alu_res = WIDTH'($signed(bus.A) < $signed(bus.B));
      OP_SLTU: alu_res = WIDTH'(bus.A < bus.B);
      OP_XOR:  alu_res = bus.A ^ bus.B;
      OP_SLL:  alu_res = bus.A << shamt;
      OP_SRL:  alu_res = bus.A >> shamt;
      OP_SRA:  alu_res = WIDTH'($signed(bus.A) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // Operand conditioning for the iterative ops; special divide cases settled up front
  always_comb begin : prep_comb
    is_iter  = (bus.op >= OP_MUL);
    is_mul   = (bus.op == OP_MUL) || (bus.op == OP_MULHU);
    is_div   = is_iter && !is_mul;
    is_sdiv  = (bus.op == OP_DIV) || (bus.op == OP_REM);
    is_rem   = (bus.op == OP_REM) || (bus.op == OP_REMU);
    a_sgn    = is_sdiv && bus.A[WIDTH-1];
    b_sgn    = is_sdiv && bus.B[WIDTH-1];
    a_mag    = a_sgn ? -bus.A : bus.A;
    b_mag    = b_sgn ? -bus.B : bus.B;
    b_zero   = (bus.B == '0);
    div_ovf  = is_sdiv && (bus.A == MIN_NEG) && (bus.B == '1);
    spec_res = '0;
    if (b_zero) begin
      spec_res = is_rem ? bus.A : '1;
    end else if (div_ovf) begin
      spec_res = is_rem ? '0 : bus.A;
    end
  end

  // One multiply step and one restoring-divide step per CALC cycle
  always_comb begin : step_comb
    hi_sum    = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    acc_step  = {hi_sum, acc[WIDTH-1:1]};
    rem_sh    = {rem, quot[WIDTH-1]};
    rem_fit   = (rem_sh >= {1'b0, mcand});
    rem_step  = rem_fit ? WIDTH'(rem_sh - {1'b0, mcand}) : rem_sh[WIDTH-1:0];
    quot_step = {quot[WIDTH-2:0], rem_fit};
    case (op_q)
      OP_MUL:          iter_res = acc_step[WIDTH-1:0];
      OP_MULHU:        iter_res = acc_step[W2-1:WIDTH];
      OP_DIV, OP_DIVU: iter_res = q_neg ? -quot_step : quot_step;
      default:         iter_res = r_neg ? -rem_step : rem_step;
    endcase
    if (special) begin
      iter_res = special_res;
    end
  end

  always_comb begin : fsm_comb
    state_nxt = state;
    ld_res    = 1'b0;
    ld_iter   = 1'b0;
    res_nxt   = alu_res;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (is_iter) begin
            state_nxt = CALC;
            ld_iter   = 1'b1;
          end else begin
            state_nxt = DONE;
            ld_res    = 1'b1;
          end
        end
      end
      CALC: begin
        if (cnt == SHW'(WIDTH - 1)) begin
          state_nxt = DONE;
          ld_res    = 1'b1;
          res_nxt   = iter_res;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      neg_q       <= 1'b0;
      cnt         <= '0;
      op_q        <= '0;
      mcand       <= '0;
      acc         <= '0;
      rem         <= '0;
      quot        <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      special     <= 1'b0;
      special_res <= '0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt == IDLE);
      busy_q  <= (state_nxt == CALC);
      valid_q <= (state_nxt == DONE);
      if (ld_res) begin
        result_q <= res_nxt;
        zero_q   <= (res_nxt == '0);
        neg_q    <= res_nxt[WIDTH-1];
      end
      if (ld_iter) begin
        op_q        <= bus.op;
        mcand       <= is_mul ? bus.A : b_mag;
        acc         <= {WIDTH'(0), bus.B};
        rem         <= '0;
        quot        <= a_mag;
        cnt         <= '0;
        q_neg       <= a_sgn ^ b_sgn;
        r_neg       <= a_sgn;
        special     <= is_div && (b_zero || div_ovf);
        special_res <= spec_res;
      end else if (state == CALC) begin
        acc  <= acc_step;
        rem  <= rem_step;
        quot <= quot_step;
        cnt  <= cnt + SHW'(1);
      end
    end
  end

  assign bus.ready  = ready_q;
  assign bus.busy   = busy_q;
  assign bus.valid  = valid_q;
  assign bus.result = result_q;
  assign bus.zero   = zero_q;
  assign bus.neg    = neg_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed and random stimulus for seq_alu; expected results queue up on issue and
// are checked, with latency and flags, when valid fires.
module tb_seq_alu;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(32)) bus ();

  seq_alu #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference behaviour built from plain wide arithmetic
  function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [4:0]  sh;
    longint      sa, sbv;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    sh  = b[4:0];
    p   = {32'd0, a} * {32'd0, b};
    case (o)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return 32'($signed(a) < $signed(b));
      4'd5:    return 32'(a < b);
      4'd6:    return a ^ b;
      4'd7:    return a << sh;
      4'd8:    return a >> sh;
      4'd9:    return 32'($signed(a) >>> sh);
      4'd10:   return p[31:0];
      4'd11:   return p[63:32];
      4'd12:   return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sbv);
      4'd13:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd14:   return (b == 0) ? a : 32'(sa % sbv);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one op, optionally pulse a stray ADD start 'poke' cycles after acceptance
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int poke);
    int          lat;
    int          busy_cycles;
    int          want_lat;
    logic [31:0] e;
    want_lat = (o >= 4'd10) ? 33 : 1;
    @(negedge clk);
    check("ready_before", 32'(bus.ready), 32'd1);
    bus.start = 1'b1;
    bus.op    = o;
    bus.A     = a;
    bus.B     = b;
    sb.push_back(exp);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = 4'($urandom);
    bus.A     = $urandom;
    bus.B     = $urandom;
    lat = 1;
    busy_cycles = 0;
    while (bus.valid !== 1'b1 && lat < 60) begin
      if (bus.busy === 1'b1) busy_cycles++;
      bus.start = (poke != 0 && lat == poke);
      if (bus.start) bus.op = 4'd0;
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    check("valid_seen", 32'(bus.valid), 32'd1);
    check("latency", 32'(lat), 32'(want_lat));
    check("busy_cycles", 32'(busy_cycles), 32'(want_lat - 1));
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("result", bus.result, e);
      check("zero", 32'(bus.zero), 32'(e == 32'd0));
      check("neg", 32'(bus.neg), 32'(e[31]));
    end
    @(posedge clk); #1;
    check("valid_pulse", 32'(bus.valid), 32'd0);
    check("ready_after", 32'(bus.ready), 32'd1);
  endtask

  initial begin
    int          nvalid;
    logic [3:0]  ro;
    logic [31:0] ra, rb;

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 4'd0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_zero", 32'(bus.zero), 32'd1);
    check("rst_neg", 32'(bus.neg), 32'd0);
    rst_n = 1'b1;

    run_op(4'd0,  32'd7,          32'hFFFF_FFF7, 32'hFFFF_FFFE, 0);
    run_op(4'd1,  32'd5,          32'd5,         32'd0,         0);
    run_op(4'd9,  32'h8000_0000,  32'h24,        32'hF800_0000, 0);
    run_op(4'd5,  32'd1,          32'hFFFF_FFFF, 32'd1,         0);
    run_op(4'd4,  32'd1,          32'hFFFF_FFFF, 32'd0,         0);
    run_op(4'd10, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         0);
    run_op(4'd11, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op(4'd12, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0);
    run_op(4'd14, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 0);
    run_op(4'd13, 32'd100,        32'd7,         32'd14,        0);
    run_op(4'd15, 32'd100,        32'd7,         32'd2,         0);
    run_op(4'd13, 32'd5,          32'd0,         32'hFFFF_FFFF, 0);
    run_op(4'd14, 32'd5,          32'd0,         32'd5,         0);
    run_op(4'd12, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op(4'd14, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0);
    run_op(4'd12, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 10);

    for (int i = 0; i < 20; i++) begin
      ro = 4'($urandom);
      ra = $urandom;
      rb = (i % 5 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      run_op(ro, ra, rb, model(ro, ra, rb), 0);
    end

    // Reset while a divide is in flight: op dropped, no valid pulse
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 4'd12;
    bus.A     = 32'hFFFF_FFF9;
    bus.B     = 32'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("busy_mid", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_ready", 32'(bus.ready), 32'd1);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_valid", 32'(bus.valid), 32'd0);
    check("mid_rst_result", bus.result, 32'd0);
    check("mid_rst_zero", 32'(bus.zero), 32'd1);
    nvalid = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.valid === 1'b1) nvalid++;
    end
    check("no_valid_after_rst", 32'(nvalid), 32'd0);
    check("idle_after_rst", 32'(bus.ready), 32'd1);

    run_op(4'd0, 32'd3, 32'd4, 32'd7, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
